// File: rtl/mul_add_seq.sv
// Sequential multiplier by repeated addition with a start/done handshake.
// It counts down the smaller operand magnitude and adds the other magnitude
// into a 2*WIDTH accumulator. The sign is applied once, when the run completes.
module mul_add_seq #(
   parameter int WIDTH    = 8,
   parameter bit SIGNED   = 1'b0,
   parameter bit SWAP_MIN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   iter
);

   localparam int PW = 2 * WIDTH;
   localparam int MW = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [MW-1:0]    a_ext;
   logic [MW-1:0]    b_ext;
   logic [MW-1:0]    a_mag;
   logic [MW-1:0]    b_mag;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] cnt_init;
   logic [MW-1:0]    addend_init;

   logic [WIDTH-1:0] cnt;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    addend;
   logic             neg;

   // Operand magnitudes and the choice of counter/addend for a new run.
   // The magnitude is one bit wider, so the most negative value is legal.
   always_comb begin
      a_neg       = 1'b0;
      b_neg       = 1'b0;
      a_ext       = {1'b0, a_in};
      b_ext       = {1'b0, b_in};
      if (SIGNED) begin
         a_neg = a_in[WIDTH-1];
         b_neg = b_in[WIDTH-1];
         a_ext = {a_in[WIDTH-1], a_in};
         b_ext = {b_in[WIDTH-1], b_in};
      end
      a_mag       = a_neg ? (~a_ext + 1'b1) : a_ext;
      b_mag       = b_neg ? (~b_ext + 1'b1) : b_ext;
      cnt_init    = b_mag[WIDTH-1:0];
      addend_init = a_mag;
      if (SWAP_MIN && (a_mag < b_mag)) begin
         cnt_init    = a_mag[WIDTH-1:0];
         addend_init = b_mag;
      end
   end

   // State register; reset aborts any run without producing a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, iterate until the counter is exhausted,
   // then spend exactly one cycle in DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load on accept, add-and-decrement while running, and apply the
   // sign to the accumulated magnitude on the final RUN edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         acc     <= '0;
         addend  <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= cnt_init;
                  addend <= PW'(addend_init);
                  acc    <= '0;
                  neg    <= a_neg ^ b_neg;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  acc <= acc + addend;
                  cnt <= cnt - 1'b1;
               end else begin
                  product <= neg ? (~acc + 1'b1) : acc;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign iter = cnt;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed testbench for mul_add_seq. Three instances cover unsigned with
// operand swapping, unsigned without swapping, and signed operation.
module tb_mul_add_seq;

   logic        clk;
   logic        rst;
   logic        start_v   [3];
   logic [7:0]  a_v       [3];
   logic [7:0]  b_v       [3];
   logic        busy_w    [3];
   logic        done_w    [3];
   logic [15:0] product_w [3];
   logic [7:0]  iter_w    [3];
   logic [15:0] prev_prod [3];

   int tests;
   int fails;

   mul_add_seq #(.WIDTH(8), .SIGNED(1'b0), .SWAP_MIN(1'b1)) u_us (
      .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
      .busy(busy_w[0]), .done(done_w[0]), .product(product_w[0]), .iter(iter_w[0])
   );

   mul_add_seq #(.WIDTH(8), .SIGNED(1'b0), .SWAP_MIN(1'b0)) u_ns (
      .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
      .busy(busy_w[1]), .done(done_w[1]), .product(product_w[1]), .iter(iter_w[1])
   );

   mul_add_seq #(.WIDTH(8), .SIGNED(1'b1), .SWAP_MIN(1'b1)) u_sg (
      .clk(clk), .rst(rst), .start(start_v[2]), .a_in(a_v[2]), .b_in(b_v[2]),
      .busy(busy_w[2]), .done(done_w[2]), .product(product_w[2]), .iter(iter_w[2])
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Run one multiply on instance sel, starting #1 after a rising edge, and
   // leave the bench positioned #1 after the edge that returns it to IDLE.
   task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int k, input string name);
      int   edges;
      bit   seen;
      logic [15:0] prev;
      prev         = prev_prod[sel];
      a_v[sel]     = a;
      b_v[sel]     = b;
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      start_v[sel] = 1'b0;
      tests++;
      if (busy_w[sel] !== 1'b1 || product_w[sel] !== prev) begin
         fails++;
         $display("[TB] FAIL %s accept: busy=%b product=%h, required busy=1 product=%h",
                  name, busy_w[sel], product_w[sel], prev);
      end
      tests++;
      if (iter_w[sel] !== k[7:0]) begin
         fails++;
         $display("[TB] FAIL %s iter_start: got %0d, required %0d", name, iter_w[sel], k);
      end
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 600) begin
         @(posedge clk);
         #1;
         edges++;
         if (done_w[sel] === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen || edges != k + 1) begin
         fails++;
         $display("[TB] FAIL %s latency: done after %0d edges (seen=%b), required %0d",
                  name, edges, seen, k + 1);
      end
      tests++;
      if (product_w[sel] !== exp_p || busy_w[sel] !== 1'b1) begin
         fails++;
         $display("[TB] FAIL %s product: got %h busy=%b, required %h busy=1",
                  name, product_w[sel], busy_w[sel], exp_p);
      end
      @(posedge clk);
      #1;
      tests++;
      if (busy_w[sel] !== 1'b0 || done_w[sel] !== 1'b0 || iter_w[sel] !== 8'd0) begin
         fails++;
         $display("[TB] FAIL %s after_done: busy=%b done=%b iter=%0d, required 0 0 0",
                  name, busy_w[sel], done_w[sel], iter_w[sel]);
      end
      prev_prod[sel] = exp_p;
   endtask

   // Reset values on every instance.
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || product_w[i] !== 16'h0000 ||
             iter_w[i] !== 8'd0) begin
            fails++;
            $display("[TB] FAIL reset[%0d]: busy=%b done=%b product=%h iter=%0d, required all 0",
                     i, busy_w[i], done_w[i], product_w[i], iter_w[i]);
         end
      end
   endtask

   // Small unsigned products, with and without counter swapping.
   task automatic test_basic();
      run_op(0, 8'd3, 8'd5, 16'd15, 3, "basic_3x5");
      run_op(1, 8'd3, 8'd5, 16'd15, 5, "noswap_3x5");
   endtask

   // A zero operand finishes one edge after the accept.
   task automatic test_zero();
      run_op(0, 8'd0, 8'd200, 16'd0, 0, "zero_a");
      run_op(0, 8'd200, 8'd0, 16'd0, 0, "zero_b");
   endtask

   // Largest unsigned operands, and a fixed b counter when swapping is off.
   task automatic test_large();
      run_op(0, 8'd255, 8'd255, 16'hFE01, 255, "max_255x255");
      run_op(1, 8'd255, 8'd2, 16'd510, 2, "noswap_255x2");
   endtask

   // Signed operands, including the most negative value.
   task automatic test_signed();
      run_op(2, 8'hFD, 8'd7, 16'hFFEB, 3, "signed_m3x7");
      run_op(2, 8'h80, 8'h80, 16'h4000, 128, "signed_m128xm128");
      run_op(2, 8'h80, 8'd1, 16'hFF80, 1, "signed_m128x1");
   endtask

   // Start pulses during RUN and DONE must not disturb the run in flight.
   task automatic test_back_to_back();
      int edges;
      bit seen;
      a_v[0]     = 8'd4;
      b_v[0]     = 8'd9;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a_v[0]     = 8'd20;
      b_v[0]     = 8'd30;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      edges = 3;
      seen  = 1'b0;
      while (!seen && edges < 600) begin
         @(posedge clk);
         #1;
         edges++;
         if (done_w[0] === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen || edges != 5 || product_w[0] !== 16'd36) begin
         fails++;
         $display("[TB] FAIL ignore_run: edges=%0d seen=%b product=%h, required 5 1 0024",
                  edges, seen, product_w[0]);
      end
      a_v[0]     = 8'd2;
      b_v[0]     = 8'd3;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      tests++;
      if (busy_w[0] !== 1'b0 || product_w[0] !== 16'd36) begin
         fails++;
         $display("[TB] FAIL ignore_done: busy=%b product=%h, required busy=0 product=0024",
                  busy_w[0], product_w[0]);
      end
      @(posedge clk);
      #1;
      tests++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
         fails++;
         $display("[TB] FAIL no_queue: busy=%b done=%b, required 0 0", busy_w[0], done_w[0]);
      end
      prev_prod[0] = 16'd36;
      run_op(0, 8'd2, 8'd3, 16'd6, 2, "fresh_2x3");
   endtask

   // Reset in the middle of a run aborts it silently; the next run is normal.
   task automatic test_reset_abort();
      int done_cnt;
      a_v[0]     = 8'd10;
      b_v[0]     = 8'd50;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tests++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || product_w[0] !== 16'h0000 ||
          iter_w[0] !== 8'd0) begin
         fails++;
         $display("[TB] FAIL abort_state: busy=%b done=%b product=%h iter=%0d, required all 0",
                  busy_w[0], done_w[0], product_w[0], iter_w[0]);
      end
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) done_cnt++;
      end
      tests++;
      if (done_cnt != 0) begin
         fails++;
         $display("[TB] FAIL abort_quiet: %0d active cycles after reset, required 0", done_cnt);
      end
      for (int i = 0; i < 3; i++) prev_prod[i] = 16'h0000;
      run_op(0, 8'd6, 8'd7, 16'd42, 6, "after_reset_6x7");
   endtask

   // Scenario sequence and summary.
   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_v[i]   = 1'b0;
         a_v[i]       = 8'd0;
         b_v[i]       = 8'd0;
         prev_prod[i] = 16'h0000;
      end
      test_reset();
      test_basic();
      test_zero();
      test_large();
      test_signed();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
